// File: rtl/boot_loader_if.sv
// boot_loader_if: control, disk-read and instruction-memory write signals of the boot copier.
interface boot_loader_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_hd;
  logic [ADDR_WIDTH-1:0] base_im;
  logic [CNT_WIDTH-1:0]  num_words;
  logic                  hd_req;
  logic [ADDR_WIDTH-1:0] hd_addr;
  logic                  hd_ack;
  logic [DATA_WIDTH-1:0] hd_data;
  logic                  im_we;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic [DATA_WIDTH-1:0] im_data;
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  count;
  modport master (
    input  start, base_hd, base_im, num_words, hd_ack, hd_data,
    output hd_req, hd_addr, im_we, im_addr, im_data, busy, done, count
  );
  modport slave (
    output start, base_hd, base_im, num_words, hd_ack, hd_data,
    input  hd_req, hd_addr, im_we, im_addr, im_data, busy, done, count
  );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: copies num_words disk words into instruction memory after a start pulse.
module boot_loader #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic          clock,
  input  logic          reset,
  boot_loader_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] bhd, bhd_n, bim, bim_n, hd_addr, hd_addr_n, im_addr, im_addr_n;
  logic [CNT_WIDTH-1:0]  nw, nw_n, idx, idx_n, count, count_n, idx_inc;
  logic [DATA_WIDTH-1:0] im_data, im_data_n;
  logic hd_req, hd_req_n, im_we, im_we_n, busy, busy_n, done, done_n;
  assign idx_inc     = idx + CNT_WIDTH'(1);
  assign bus.hd_req  = hd_req;
  assign bus.hd_addr = hd_addr;
  assign bus.im_we   = im_we;
  assign bus.im_addr = im_addr;
  assign bus.im_data = im_data;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.count   = count;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bhd     <= '0;
      bim     <= '0;
      nw      <= '0;
      idx     <= '0;
      count   <= '0;
      hd_req  <= 1'b0;
      hd_addr <= '0;
      im_we   <= 1'b0;
      im_addr <= '0;
      im_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      bhd     <= bhd_n;
      bim     <= bim_n;
      nw      <= nw_n;
      idx     <= idx_n;
      count   <= count_n;
      hd_req  <= hd_req_n;
      hd_addr <= hd_addr_n;
      im_we   <= im_we_n;
      im_addr <= im_addr_n;
      im_data <= im_data_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end
  // Outputs are computed for the next state and registered, so none depends combinationally on an input.
  always_comb begin
    state_n   = state;
    bhd_n     = bhd;
    bim_n     = bim;
    nw_n      = nw;
    idx_n     = idx;
    count_n   = count;
    hd_req_n  = hd_req;
    hd_addr_n = hd_addr;
    im_we_n   = 1'b0;
    im_addr_n = im_addr;
    im_data_n = im_data;
    busy_n    = busy;
    done_n    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        bhd_n     = bus.base_hd;
        bim_n     = bus.base_im;
        nw_n      = bus.num_words;
        idx_n     = '0;
        count_n   = '0;
        busy_n    = 1'b1;
        done_n    = bus.num_words == '0;
        hd_req_n  = bus.num_words != '0;
        hd_addr_n = bus.num_words != '0 ? bus.base_hd : hd_addr;
        state_n   = bus.num_words == '0 ? DONE : REQ;
      end
      REQ: if (bus.hd_ack) begin
        hd_req_n  = 1'b0;
        im_we_n   = 1'b1;
        im_addr_n = bim + ADDR_WIDTH'(idx);
        im_data_n = bus.hd_data;
        state_n   = WRITE;
      end
      WRITE: begin
        idx_n     = idx_inc;
        count_n   = count + CNT_WIDTH'(1);
        done_n    = idx_inc == nw;
        hd_req_n  = idx_inc != nw;
        hd_addr_n = idx_inc != nw ? bhd + ADDR_WIDTH'(idx_inc) : hd_addr;
        state_n   = idx_inc == nw ? DONE : REQ;
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
